// File: rtl/litedram_axi_gate.sv
`default_nettype none
// ============================================================================
// Module   : litedram_axi_gate
// Function : AXI4 gate between the SoC interconnect (s_*) and the litedram
//            AXI slave port (m_*). Holds all traffic until DDR calibration
//            finishes, then passes traffic through with per-direction
//            outstanding-transaction limits. If calibration fails, it
//            completes every transaction locally with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module litedram_axi_gate #(
    parameter int ID_WIDTH  = 1,
    parameter int MAX_OUTST = 4
) (
    input  logic                user_clk,
    input  logic                user_rst,
    input  logic                init_done,
    input  logic                init_error,
    output logic [1:0]          gate_state,

    // master side (SoC interconnect)
    input  logic [ID_WIDTH-1:0] s_awid,
    input  logic [28:0]         s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [3:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [63:0]         s_wdata,
    input  logic [7:0]          s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_WIDTH-1:0] s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_WIDTH-1:0] s_arid,
    input  logic [28:0]         s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [3:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_WIDTH-1:0] s_rid,
    output logic [63:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,

    // slave side (litedram_top)
    output logic [ID_WIDTH-1:0] m_awid,
    output logic [28:0]         m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [3:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [63:0]         m_wdata,
    output logic [7:0]          m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_WIDTH-1:0] m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ID_WIDTH-1:0] m_arid,
    output logic [28:0]         m_araddr,
    output logic [7:0]          m_arlen,
    output logic [3:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_WIDTH-1:0] m_rid,
    input  logic [63:0]         m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready
);

    localparam int              CW       = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0]   C_MAX    = CW'(MAX_OUTST);
    localparam logic [1:0]      C_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_RUN       = 2'd1,
        ST_ERROR     = 2'd2
    } gate_st_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_st_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_st_t;

    gate_st_t              r_gate;
    wr_st_t                r_wst;
    rd_st_t                r_rst;
    logic [CW-1:0]         r_wr_cnt;
    logic [CW-1:0]         r_rd_cnt;
    logic [ID_WIDTH-1:0]   r_err_bid;
    logic [ID_WIDTH-1:0]   r_err_rid;
    logic [8:0]            r_rd_beats;

    logic                  w_run;
    logic                  w_err;
    logic                  w_wr_full;
    logic                  w_rd_full;
    logic                  w_aw_hs;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_rl_hs;

    assign w_run     = (r_gate == ST_RUN);
    assign w_err     = (r_gate == ST_ERROR);
    assign w_wr_full = (r_wr_cnt == C_MAX);
    assign w_rd_full = (r_rd_cnt == C_MAX);

    assign gate_state = r_gate;

    // Request payloads are wired straight through; only the valids are gated.
    assign m_awid    = s_awid;
    assign m_awaddr  = s_awaddr;
    assign m_awlen   = s_awlen;
    assign m_awsize  = s_awsize;
    assign m_awburst = s_awburst;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign m_wlast   = s_wlast;
    assign m_arid    = s_arid;
    assign m_araddr  = s_araddr;
    assign m_arlen   = s_arlen;
    assign m_arsize  = s_arsize;
    assign m_arburst = s_arburst;

    // Slave-facing handshakes: only possible in RUN, address channels throttled.
    assign m_awvalid = w_run & s_awvalid & ~w_wr_full;
    assign m_wvalid  = w_run & s_wvalid;
    assign m_bready  = w_run & s_bready;
    assign m_arvalid = w_run & s_arvalid & ~w_rd_full;
    assign m_rready  = w_run & s_rready;

    // Master-facing channels: pass-through in RUN, local terminator in ERROR.
    assign s_awready = (w_run & m_awready & ~w_wr_full) | (w_err & (r_wst == W_IDLE));
    assign s_wready  = (w_run & m_wready) | (w_err & (r_wst == W_DATA));
    assign s_bvalid  = (w_run & m_bvalid) | (w_err & (r_wst == W_RESP));
    assign s_bid     = w_err ? r_err_bid : m_bid;
    assign s_bresp   = w_err ? C_SLVERR : m_bresp;
    assign s_arready = (w_run & m_arready & ~w_rd_full) | (w_err & (r_rst == R_IDLE));
    assign s_rvalid  = (w_run & m_rvalid) | (w_err & (r_rst == R_DATA));
    assign s_rid     = w_err ? r_err_rid : m_rid;
    assign s_rdata   = w_err ? 64'd0 : m_rdata;
    assign s_rresp   = w_err ? C_SLVERR : m_rresp;
    assign s_rlast   = w_err ? (r_rd_beats == 9'd1) : m_rlast;

    // Only slave-side handshakes occupy an outstanding slot.
    assign w_aw_hs = m_awvalid & m_awready;
    assign w_b_hs  = m_bvalid & m_bready;
    assign w_ar_hs = m_arvalid & m_arready;
    assign w_rl_hs = m_rvalid & m_rready & m_rlast;

    // Top-level gate: wait for calibration, then RUN or ERROR until reset.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_gate <= ST_WAIT_INIT;
        end else if (r_gate == ST_WAIT_INIT) begin
            if (init_error)
                r_gate <= ST_ERROR;
            else if (init_done)
                r_gate <= ST_RUN;
        end
    end

    // Outstanding write count: AW accepted minus B returned.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_wr_cnt <= '0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_wr_cnt <= r_wr_cnt + 1'b1;
                2'b01:   r_wr_cnt <= r_wr_cnt - 1'b1;
                default: r_wr_cnt <= r_wr_cnt;
            endcase
        end
    end

    // Outstanding read count: AR accepted minus final R beat returned.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_rd_cnt <= '0;
        end else begin
            case ({w_ar_hs, w_rl_hs})
                2'b10:   r_rd_cnt <= r_rd_cnt + 1'b1;
                2'b01:   r_rd_cnt <= r_rd_cnt - 1'b1;
                default: r_rd_cnt <= r_rd_cnt;
            endcase
        end
    end

    // ERROR-mode write terminator: accept AW, swallow the burst, answer SLVERR.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_wst     <= W_IDLE;
            r_err_bid <= '0;
        end else if (w_err) begin
            case (r_wst)
                W_IDLE: if (s_awvalid) begin
                    r_err_bid <= s_awid;
                    r_wst     <= W_DATA;
                end
                W_DATA: if (s_wvalid && s_wlast)
                    r_wst <= W_RESP;
                W_RESP: if (s_bready)
                    r_wst <= W_IDLE;
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    // ERROR-mode read terminator: return arlen+1 zero beats with SLVERR.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_rst      <= R_IDLE;
            r_err_rid  <= '0;
            r_rd_beats <= '0;
        end else if (w_err) begin
            case (r_rst)
                R_IDLE: if (s_arvalid) begin
                    r_err_rid  <= s_arid;
                    r_rd_beats <= {1'b0, s_arlen} + 9'd1;
                    r_rst      <= R_DATA;
                end
                R_DATA: if (s_rready) begin
                    if (r_rd_beats == 9'd1)
                        r_rst <= R_IDLE;
                    r_rd_beats <= r_rd_beats - 9'd1;
                end
                default: r_rst <= R_IDLE;
            endcase
        end
    end

    // litedram only answers requests it was given, so counters never underflow.
    a_no_wr_underflow : assert property (@(posedge user_clk) disable iff (user_rst)
        !(w_b_hs && !w_aw_hs && (r_wr_cnt == '0)));
    a_no_rd_underflow : assert property (@(posedge user_clk) disable iff (user_rst)
        !(w_rl_hs && !w_ar_hs && (r_rd_cnt == '0)));

endmodule
`default_nettype wire
